// File: rtl/elevator_ctrl_param.sv
`default_nettype none
// =====================================================================
// elevator_ctrl_param : N-floor collective (SCAN) elevator car controller
// Revision: 1.0
// =====================================================================
module elevator_ctrl_param #(
  parameter int FLOORS = 4,
  parameter int DOOR_W = 4,
  parameter int TRAVEL = 2,
  parameter int DWELL  = 3,
  localparam int FW    = $clog2(FLOORS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [FLOORS-1:0] Req,
  output logic [FLOORS-1:0] Pending,
  output logic [FW-1:0]     CurFlr,
  output logic              Dir,
  output logic              MotorEn,
  output logic [DOOR_W-1:0] DoorAnim,
  output logic              flrChg,
  output logic              Idle
);

  localparam int c_PW  = $clog2(DOOR_W + 1);
  localparam int c_TW  = (TRAVEL > 1) ? $clog2(TRAVEL) : 1;
  localparam int c_DWW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [c_PW-1:0]  c_DOOR_FULL   = c_PW'(DOOR_W);
  localparam logic [c_TW-1:0]  c_TRAVEL_LAST = c_TW'(TRAVEL - 1);
  localparam logic [c_DWW-1:0] c_DWELL_LD    = c_DWW'(DWELL - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLOSING = 3'd1,
    S_MOVING  = 3'd2,
    S_ARRIVED = 3'd3,
    S_OPENING = 3'd4,
    S_OPEN    = 3'd5
  } state_t;

  state_t             r_state;
  logic [FW-1:0]      r_flr;
  logic               r_dir;
  logic [FLOORS-1:0]  r_pend;
  logic [c_PW-1:0]    r_door;
  logic [c_TW-1:0]    r_travel;
  logic [c_DWW-1:0]   r_dwell;
  logic               r_flrchg;

  logic               w_above;
  logic               w_below;
  logic               w_here;
  logic               w_ahead;
  logic               w_behind;
  logic [FLOORS-1:0]  w_clr;

  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (FW'(i) > r_flr) w_above = w_above | r_pend[i];
      if (FW'(i) < r_flr) w_below = w_below | r_pend[i];
    end
  end

  assign w_here   = r_pend[r_flr];
  assign w_ahead  = r_dir ? w_above : w_below;
  assign w_behind = r_dir ? w_below : w_above;
  // The call at the current floor is served while the door is opening or open.
  assign w_clr    = (r_state == S_OPENING || r_state == S_OPEN) ?
                    (FLOORS'(1) << r_flr) : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_flr    <= '0;
      r_dir    <= 1'b1;
      r_pend   <= '0;
      r_door   <= '0;
      r_travel <= '0;
      r_dwell  <= '0;
      r_flrchg <= 1'b0;
    end else begin
      r_pend   <= (r_pend | Req) & ~w_clr;
      r_flrchg <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_door <= '0;
          if (w_here) begin
            r_state <= S_OPEN;
            r_dwell <= c_DWELL_LD;
          end else if (w_above) begin
            r_dir   <= 1'b1;
            r_state <= S_CLOSING;
          end else if (w_below) begin
            r_dir   <= 1'b0;
            r_state <= S_CLOSING;
          end
        end
        S_CLOSING: begin
          if (w_here) begin
            r_state <= S_OPENING;
          end else if (r_door == c_DOOR_FULL) begin
            r_state  <= S_MOVING;
            r_travel <= '0;
          end else begin
            r_door <= r_door + c_PW'(1);
          end
        end
        S_MOVING: begin
          if (r_travel == c_TRAVEL_LAST) begin
            r_flr    <= r_dir ? (r_flr + FW'(1)) : (r_flr - FW'(1));
            r_flrchg <= 1'b1;
            r_state  <= S_ARRIVED;
          end else begin
            r_travel <= r_travel + c_TW'(1);
          end
        end
        S_ARRIVED: begin
          if (w_here) begin
            r_state <= S_OPENING;
          end else if (w_ahead) begin
            r_state  <= S_MOVING;
            r_travel <= '0;
          end else if (w_behind) begin
            r_dir    <= ~r_dir;
            r_state  <= S_MOVING;
            r_travel <= '0;
          end else begin
            r_state <= S_OPENING;
          end
        end
        S_OPENING: begin
          if (r_door == '0) begin
            r_state <= S_OPEN;
            r_dwell <= c_DWELL_LD;
          end else begin
            r_door <= r_door - c_PW'(1);
          end
        end
        S_OPEN: begin
          r_door <= '0;
          if (Req[r_flr]) begin
            r_dwell <= c_DWELL_LD;
          end else if (r_dwell == '0) begin
            if (w_above || w_below) begin
              if (!w_ahead) r_dir <= ~r_dir;
              r_state <= S_CLOSING;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_dwell <= r_dwell - c_DWW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_door  <= '0;
        end
      endcase
    end
  end

  // Thermometer: the top r_door bits are set.
  always_comb begin
    DoorAnim = '0;
    for (int i = 0; i < DOOR_W; i++)
      DoorAnim[i] = (c_PW'(DOOR_W - 1 - i) < r_door);
  end

  assign Pending = r_pend;
  assign CurFlr  = r_flr;
  assign Dir     = r_dir;
  assign MotorEn = (r_state == S_MOVING);
  assign Idle    = (r_state == S_IDLE);
  assign flrChg  = r_flrchg;

endmodule
`default_nettype wire

// File: tb/tb_elevator_ctrl_param.sv
`default_nettype none
// =====================================================================
// tb_elevator_ctrl_param : scoreboard bench for elevator_ctrl_param
// Revision: 1.0
// =====================================================================
module tb_elevator_ctrl_param;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST = 1'b1;
  logic [3:0] Req = '0;
  logic [3:0] Pending;
  logic [1:0] CurFlr;
  logic       Dir, MotorEn, flrChg, Idle;
  logic [3:0] DoorAnim;

  logic       RST2 = 1'b1;
  logic [7:0] Req2 = '0;
  logic [7:0] Pending2;
  logic [2:0] CurFlr2;
  logic       Dir2, MotorEn2, flrChg2, Idle2;
  logic [5:0] DoorAnim2;

  elevator_ctrl_param dut (
    .CLK(CLK), .RST(RST), .Req(Req), .Pending(Pending), .CurFlr(CurFlr),
    .Dir(Dir), .MotorEn(MotorEn), .DoorAnim(DoorAnim), .flrChg(flrChg), .Idle(Idle)
  );

  elevator_ctrl_param #(.FLOORS(8), .DOOR_W(6), .TRAVEL(1), .DWELL(3)) dut2 (
    .CLK(CLK), .RST(RST2), .Req(Req2), .Pending(Pending2), .CurFlr(CurFlr2),
    .Dir(Dir2), .MotorEn(MotorEn2), .DoorAnim(DoorAnim2), .flrChg(flrChg2), .Idle(Idle2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Expected {Dir, CurFlr} at each floor change, and floor of each door-open completion.
  logic [2:0] q_flr [$];
  logic [1:0] q_open [$];
  logic [3:0] prev_door = '0;

  logic above_t, below_t;
  assign above_t = (Pending >> (CurFlr + 3'd1)) != 4'b0000;
  assign below_t = (Pending & ((4'b0001 << CurFlr) - 4'b0001)) != 4'b0000;

  always @(negedge CLK) begin
    if (flrChg === 1'b1) begin
      vectors++;
      if (q_flr.size() == 0) begin
        miscompares++;
        $display("FAIL flr_event: unexpected change to floor %0d dir %0b", CurFlr, Dir);
      end else begin
        if ({Dir, CurFlr} !== q_flr[0]) begin
          miscompares++;
          $display("FAIL flr_event: dir/floor %b, required %b", {Dir, CurFlr}, q_flr[0]);
        end
        q_flr.delete(0);
      end
    end
    if (prev_door != 4'b0000 && DoorAnim == 4'b0000) begin
      vectors++;
      if (q_open.size() == 0) begin
        miscompares++;
        $display("FAIL open_event: unexpected door open at floor %0d", CurFlr);
      end else begin
        if (CurFlr !== q_open[0]) begin
          miscompares++;
          $display("FAIL open_event: opened at floor %0d, required %0d", CurFlr, q_open[0]);
        end
        q_open.delete(0);
      end
    end
    if (MotorEn === 1'b1) begin
      vectors++;
      if (!(Dir ? above_t : below_t)) begin
        miscompares++;
        $display("FAIL motor_no_call: moving dir %0b at floor %0d with Pending %b", Dir, CurFlr, Pending);
      end
    end
    prev_door <= DoorAnim;
  end

  task automatic pulse(input logic [3:0] v);
    Req = v;
    @(negedge CLK);
    Req = '0;
  endtask

  task automatic reset_car();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    q_flr.delete();
    q_open.delete();
  endtask

  task automatic settle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (q_flr.size() == 0 && q_open.size() == 0 && Idle === 1'b1 && Pending === 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    Req = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if ({CurFlr, DoorAnim, Idle, Pending, MotorEn, Dir, flrChg} !== 15'b00_0000_1_0000_0_1_0) begin
      miscompares++;
      $display("FAIL reset_hold: flr/door/idle/pend/mot/dir/chg %b, required 000000100000010",
               {CurFlr, DoorAnim, Idle, Pending, MotorEn, Dir, flrChg});
    end
    RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({CurFlr, DoorAnim, Idle, Pending, MotorEn, Dir, flrChg} !== 15'b00_0000_1_0000_0_1_0) begin
      miscompares++;
      $display("FAIL reset_release: flr/door/idle/pend/mot/dir/chg %b, required 000000100000010",
               {CurFlr, DoorAnim, Idle, Pending, MotorEn, Dir, flrChg});
    end
  endtask

  task automatic test_single_call();
    logic [7:0] tbl [20];
    // {DoorAnim, MotorEn, Idle, CurFlr} one row per cycle after the call is latched
    tbl = '{8'b0000_0_0_00, 8'b1000_0_0_00, 8'b1100_0_0_00, 8'b1110_0_0_00, 8'b1111_0_0_00,
            8'b1111_1_0_00, 8'b1111_1_0_00, 8'b1111_0_0_01, 8'b1111_1_0_01, 8'b1111_1_0_01,
            8'b1111_0_0_10, 8'b1111_0_0_10, 8'b1110_0_0_10, 8'b1100_0_0_10, 8'b1000_0_0_10,
            8'b0000_0_0_10, 8'b0000_0_0_10, 8'b0000_0_0_10, 8'b0000_0_0_10, 8'b0000_0_1_10};
    q_flr.push_back(3'b101);
    q_flr.push_back(3'b110);
    q_open.push_back(2'd2);
    pulse(4'b0100);
    vectors++;
    if (Pending !== 4'b0100 || Idle !== 1'b1) begin
      miscompares++;
      $display("FAIL single_latch: Pending %b Idle %b, required 0100 1", Pending, Idle);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      vectors++;
      if ({DoorAnim, MotorEn, Idle, CurFlr} !== tbl[k]) begin
        miscompares++;
        $display("FAIL single_trace step %0d: door/mot/idle/flr %b, required %b",
                 k + 1, {DoorAnim, MotorEn, Idle, CurFlr}, tbl[k]);
      end
    end
    vectors++;
    if (Pending !== 4'b0000 || q_flr.size() != 0 || q_open.size() != 0) begin
      miscompares++;
      $display("FAIL single_done: Pending %b, events left %0d, required 0000 and 0",
               Pending, q_flr.size() + q_open.size());
    end
  endtask

  task automatic test_intermediate_stop();
    bit ok;
    reset_car();
    vectors++;
    if (CurFlr !== 2'd0 || Idle !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_reset: CurFlr %0d Idle %b, required 0 1", CurFlr, Idle);
    end
    q_flr.push_back(3'b101);
    q_flr.push_back(3'b110);
    q_flr.push_back(3'b111);
    q_open.push_back(2'd1);
    q_open.push_back(2'd3);
    pulse(4'b1000);
    repeat (2) @(negedge CLK);
    pulse(4'b0010);
    settle(300, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL stop_timeout: events left %0d Pending %b, required 0 0000",
               q_flr.size() + q_open.size(), Pending);
    end
    vectors++;
    if ({Dir, CurFlr} !== 3'b111) begin
      miscompares++;
      $display("FAIL stop_final: dir/floor %b, required 111", {Dir, CurFlr});
    end
  endtask

  task automatic test_sweep_reverse();
    bit ok;
    reset_car();
    q_flr = '{3'b101, 3'b110, 3'b111, 3'b010, 3'b001, 3'b000};
    q_open = '{2'd2, 2'd3, 2'd0};
    pulse(4'b0100);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (q_open.size() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL sweep_reach2: door never opened at floor 2, CurFlr %0d", CurFlr);
    end
    pulse(4'b1001);
    vectors++;
    if (Pending !== 4'b1001 || Dir !== 1'b1) begin
      miscompares++;
      $display("FAIL sweep_latch: Pending %b Dir %b, required 1001 1", Pending, Dir);
    end
    settle(400, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL sweep_timeout: events left %0d Pending %b, required 0 0000",
               q_flr.size() + q_open.size(), Pending);
    end
    vectors++;
    if ({Dir, CurFlr} !== 3'b000) begin
      miscompares++;
      $display("FAIL sweep_final: dir/floor %b, required 000", {Dir, CurFlr});
    end
  endtask

  task automatic test_reopen();
    bit ok;
    logic [4:0] tbl [10];
    // {DoorAnim, Idle} from the cycle after the same-floor call is sampled
    tbl = '{5'b1110_0, 5'b1110_0, 5'b1100_0, 5'b1000_0, 5'b0000_0,
            5'b0000_0, 5'b0000_0, 5'b0000_0, 5'b0000_0, 5'b1000_0};
    q_flr.push_back(3'b101);
    q_flr.push_back(3'b110);
    q_open.push_back(2'd0);
    q_open.push_back(2'd2);
    pulse(4'b0100);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (DoorAnim == 4'b1100) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL reopen_wait: DoorAnim %b never reached 1100", DoorAnim);
    end
    pulse(4'b0001);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge CLK);
      vectors++;
      if ({DoorAnim, Idle} !== tbl[k]) begin
        miscompares++;
        $display("FAIL reopen_trace step %0d: door/idle %b, required %b", k, {DoorAnim, Idle}, tbl[k]);
      end
    end
    settle(300, ok);
    vectors++;
    if (!ok || CurFlr !== 2'd2) begin
      miscompares++;
      $display("FAIL reopen_final: settled %b CurFlr %0d, required 1 2", ok, CurFlr);
    end
  endtask

  task automatic test_all_calls();
    bit ok;
    reset_car();
    q_flr = '{3'b101, 3'b110, 3'b111};
    q_open = '{2'd1, 2'd2, 2'd3};
    pulse(4'b1111);
    vectors++;
    if (Pending !== 4'b1111 || Idle !== 1'b1) begin
      miscompares++;
      $display("FAIL all_latch: Pending %b Idle %b, required 1111 1", Pending, Idle);
    end
    @(negedge CLK);
    vectors++;
    if (Idle !== 1'b0 || DoorAnim !== 4'b0000 || MotorEn !== 1'b0) begin
      miscompares++;
      $display("FAIL all_open_here: Idle %b DoorAnim %b MotorEn %b, required 0 0000 0", Idle, DoorAnim, MotorEn);
    end
    settle(400, ok);
    vectors++;
    if (!ok || {Dir, CurFlr} !== 3'b111) begin
      miscompares++;
      $display("FAIL all_final: settled %b dir/floor %b, required 1 111", ok, {Dir, CurFlr});
    end
  endtask

  task automatic test_reset_moving();
    bit ok;
    RST2 = 1'b0;
    @(negedge CLK);
    Req2 = 8'h80;
    @(negedge CLK);
    Req2 = '0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (MotorEn2 === 1'b1 && CurFlr2 == 3'd3) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL big_moving: never moving at floor 3, CurFlr %0d MotorEn %b", CurFlr2, MotorEn2);
    end
    vectors++;
    if ({DoorAnim2, Dir2, Pending2} !== {6'b111111, 1'b1, 8'h80}) begin
      miscompares++;
      $display("FAIL big_motion_state: door/dir/pend %b, required 111111_1_10000000", {DoorAnim2, Dir2, Pending2});
    end
    RST2 = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({CurFlr2, MotorEn2, DoorAnim2, Pending2, Idle2, flrChg2} !== {3'd0, 1'b0, 6'd0, 8'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL big_reset: flr/mot/door/pend/idle/chg %b, required 0000000000000000000010",
               {CurFlr2, MotorEn2, DoorAnim2, Pending2, Idle2, flrChg2});
    end
    RST2 = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++;
    if (Idle2 !== 1'b1 || MotorEn2 !== 1'b0 || CurFlr2 !== 3'd0) begin
      miscompares++;
      $display("FAIL big_after_reset: Idle %b MotorEn %b CurFlr %0d, required 1 0 0", Idle2, MotorEn2, CurFlr2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_call();
    test_intermediate_stop();
    test_sweep_reverse();
    test_reopen();
    test_all_calls();
    test_reset_moving();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
